// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner and its consumers.
package keypad_pkg;

  localparam int unsigned KP_CODE_W = 8;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } kp_state_e;

  typedef struct packed {
    logic [KP_CODE_W-1:0] code;
    logic                 is_long;
  } kp_evt_t;

  function automatic logic [KP_CODE_W-1:0] key_index(input logic [31:0] row,
                                                     input logic [31:0] col,
                                                     input logic [31:0] cols);
    logic [31:0] idx;
    idx = row * cols + col;
    return idx[KP_CODE_W-1:0];
  endfunction

  // ASCII legend of the 4x4 doorlock keypad, indexed by key_index().
  function automatic logic [7:0] key_char(input logic [3:0] idx);
    logic [7:0] ch;
    case (idx)
      4'd0:  ch = "1";
      4'd1:  ch = "2";
      4'd2:  ch = "3";
      4'd3:  ch = "A";
      4'd4:  ch = "4";
      4'd5:  ch = "5";
      4'd6:  ch = "6";
      4'd7:  ch = "B";
      4'd8:  ch = "7";
      4'd9:  ch = "8";
      4'd10: ch = "9";
      4'd11: ch = "C";
      4'd12: ch = "*";
      4'd13: ch = "0";
      4'd14: ch = "#";
      default: ch = "D";
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Small synchronous event FIFO with registered head, full and empty flags.
module keypad_evt_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  kp_evt_t push_data,
  input  logic    pop,
  output kp_evt_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);

  kp_evt_t         mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, rd_q, rd_next_c;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic            push_ok_c, pop_ok_c;
  kp_evt_t         head_d;

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  assign pop_ok_c  = pop && !empty;
  assign push_ok_c = push && (!full || pop_ok_c);
  assign rd_next_c = rd_q + AW'(1);
  assign cnt_d     = cnt_q + NW'(push_ok_c) - NW'(pop_ok_c);

  always_comb begin
    head_d = head;
    if (pop_ok_c) begin
      if (cnt_q == NW'(1)) begin
        if (push_ok_c) head_d = push_data;
      end else begin
        head_d = mem[rd_next_c];
      end
    end else if (empty && push_ok_c) begin
      head_d = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      head  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push_ok_c) wr_q <= wr_q + AW'(1);
      if (pop_ok_c)  rd_q <= rd_next_c;
      cnt_q <= cnt_d;
      head  <= head_d;
      full  <= (cnt_d == NW'(FIFO_DEPTH));
      empty <= (cnt_d == NW'(0));
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row drive, column sync, press/release debounce,
// long-press detection and a buffered event stream for the doorlock FSM.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS              = 4,
  parameter int unsigned COLS              = 4,
  parameter int unsigned SCAN_DIV          = 16,
  parameter int unsigned DEBOUNCE_CYCLES   = 32,
  parameter int unsigned LONG_PRESS_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [COLS-1:0]                 col_n,
  output logic [ROWS-1:0]                 row_n,
  output logic                            evt_valid,
  input  logic                            evt_ready,
  output logic [$clog2(ROWS*COLS)-1:0]    evt_code,
  output logic                            evt_long,
  output logic                            key_down,
  output logic                            overflow
);

  localparam int unsigned CW       = $clog2(ROWS * COLS);
  localparam int unsigned RW       = $clog2(ROWS);
  localparam int unsigned CIW      = $clog2(COLS);
  localparam int unsigned ZW       = $clog2(COLS + 1);
  localparam int unsigned DIVW     = $clog2(SCAN_DIV + 1);
  localparam int unsigned DEBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_MAX = (LONG_PRESS_CYCLES == 0) ? 1 : LONG_PRESS_CYCLES;
  localparam int unsigned HOLDW    = $clog2(HOLD_MAX + 1);

  kp_state_e          state_q, state_d;
  logic [RW-1:0]      row_q, row_d, next_row_c;
  logic [CIW-1:0]     col_q, col_d, col_c;
  logic [DIVW-1:0]    div_q, div_d;
  logic [DEBW-1:0]    deb_q, deb_d;
  logic [HOLDW-1:0]   hold_q, hold_d;
  logic [COLS-1:0]    sync_q, cs_q;
  logic [ZW-1:0]      zeros_c;
  logic               single_c, idle_c, match_c;
  logic               push_c, push_long_c, pop_c;
  logic               fifo_full, fifo_empty;
  kp_evt_t            push_evt_c, head;
  logic               unused_head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      cs_q   <= '1;
    end else begin
      sync_q <= col_n;
      cs_q   <= sync_q;
    end
  end

  // Count closed columns; col_c is only meaningful when exactly one is closed.
  always_comb begin
    zeros_c = '0;
    col_c   = '0;
    for (int i = 0; i < COLS; i++) begin
      if (!cs_q[i]) begin
        zeros_c = zeros_c + ZW'(1);
        col_c   = CIW'(i);
      end
    end
  end

  assign single_c   = (zeros_c == ZW'(1));
  assign idle_c     = &cs_q;
  assign match_c    = single_c && (col_c == col_q);
  assign next_row_c = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    div_d       = div_q;
    deb_d       = deb_q;
    hold_d      = hold_q;
    push_c      = 1'b0;
    push_long_c = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (div_q == DIVW'(SCAN_DIV - 1)) begin
          div_d = '0;
          if (single_c) begin
            col_d   = col_c;
            deb_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            row_d = next_row_c;
          end
        end else begin
          div_d = div_q + DIVW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (!match_c) begin
          state_d = ST_SCAN;
          row_d   = next_row_c;
          div_d   = '0;
        end else if (deb_q == DEBW'(DEBOUNCE_CYCLES - 1)) begin
          push_c  = 1'b1;
          hold_d  = '0;
          state_d = ST_HELD;
        end else begin
          deb_d = deb_q + DEBW'(1);
        end
      end
      ST_HELD: begin
        if (!match_c) begin
          state_d = ST_RELEASE;
          deb_d   = '0;
        end else begin
          if (hold_q != HOLDW'(HOLD_MAX)) hold_d = hold_q + HOLDW'(1);
          // Fires on the step into HOLD_MAX; saturation keeps it once per press.
          if (LONG_PRESS_CYCLES != 0 && hold_q == HOLDW'(HOLD_MAX - 1)) begin
            push_c      = 1'b1;
            push_long_c = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        if (idle_c) begin
          if (deb_q == DEBW'(DEBOUNCE_CYCLES - 1)) begin
            state_d = ST_SCAN;
            row_d   = next_row_c;
            div_d   = '0;
          end else begin
            deb_d = deb_q + DEBW'(1);
          end
        end else if (match_c) begin
          state_d = ST_HELD;
        end else begin
          deb_d = '0;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_SCAN;
      row_q    <= '0;
      col_q    <= '0;
      div_q    <= '0;
      deb_q    <= '0;
      hold_q   <= '0;
      row_n    <= '1;
      key_down <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      div_q    <= div_d;
      deb_q    <= deb_d;
      hold_q   <= hold_d;
      row_n    <= ~(ROWS'(1) << row_d);
      key_down <= (state_d == ST_HELD) || (state_d == ST_RELEASE);
      overflow <= push_c && fifo_full && !pop_c;
    end
  end

  assign push_evt_c.code    = key_index(32'(row_q), 32'(col_q), COLS);
  assign push_evt_c.is_long = push_long_c;
  assign pop_c              = evt_valid && evt_ready;

  keypad_evt_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (push_evt_c),
    .pop       (pop_c),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign evt_valid   = ~fifo_empty;
  assign evt_code    = head.code[CW-1:0];
  assign evt_long    = head.is_long;
  assign unused_head = ^head.code;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner that drives active-low rows, samples active-low columns, debounces press and release, and reports press and long-press events through a small event FIFO with a valid/ready handshake. It sits between the keypad pins and the doorlock control FSM. It supports arbitrary ROWS×COLS matrices, rejects multi-key (ghost) presses, and decouples event consumption from scanning.

## Interface
- ROWS, 4, number of driven rows (≥2)
- COLS, 4, number of sensed columns (≥2)
- SCAN_DIV, 16, cycles each row is driven during scan (≥4)
- DEBOUNCE_CYCLES, 32, consecutive stable cycles to confirm press or release (≥1)
- LONG_PRESS_CYCLES, 50000, held cycles after confirmed press before long event; 0 disables
- FIFO_DEPTH, 4, event FIFO entries (power of 2, ≥2)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- col_n  in  COLS  column inputs, low = key closed, asynchronous to clk
- row_n  out  ROWS  row drives, one-hot low while scanning
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts head this cycle
- evt_code  out  CW  key index = row*COLS + col, CW = $clog2(ROWS*COLS)
- evt_long  out  1  head event is a long-press
- key_down  out  1  a debounced key is currently held
- overflow  out  1  one-cycle pulse: event dropped, FIFO full

## Operation
- col_n passes through a 2-flop synchronizer; all decisions use the synchronized value `cs`.
- "single(c)" means exactly one bit of `cs` is low, at index c.
- SCAN: drive row r low for SCAN_DIV cycles, then evaluate `cs` on the last cycle of the slot.
  - single(c): capture (r,c), keep row r driven, clear the counter, go to DEBOUNCE.
  - No bit low or more than one bit low: advance r, wrapping from ROWS-1 to 0.
- DEBOUNCE: each cycle, if single(c) matches the captured column, increment the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1, push {code, long=0}, clear the hold counter and go to HELD.
  - On any mismatch, go to SCAN at row r+1.
- HELD: while single(c) matches, increment the hold counter, saturating.
  - When it equals LONG_PRESS_CYCLES (and that parameter is nonzero), push {code, long=1}, exactly once per press.
  - On mismatch, go to RELEASE with the counter cleared.
- RELEASE: a cycle with no `cs` bit low increments the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1, go to SCAN at row r+1.
  - If single(c) of the captured column reappears, return to HELD with the hold counter preserved and no new event.
  - Any other pattern restarts the counter.
- key_down = 1 in HELD and RELEASE.
- FIFO:
  - A push while full drops the event and pulses overflow.
  - A simultaneous push and pop while full is accepted, with no overflow.
  - A pop occurs on evt_valid && evt_ready.
  - evt_code and evt_long are registered from the head and stable while evt_valid && !evt_ready.
- Counter widths are $clog2 of the relevant maximum + 1. No arithmetic wraps except the row index.

## Timing
- Reset values: row_n = all 1s, evt_valid = 0, evt_code = 0, evt_long = 0, key_down = 0, overflow = 0. State = SCAN, r = 0, FIFO empty.
- Reset mid-press or mid-handshake flushes the FIFO and pending events. No event is emitted for a key still held at deassertion until it has been re-detected and debounced from SCAN.
- First cycle after reset deassertion: row_n[0] = 0.
- Press latency, measured from the capture cycle: push at capture + DEBOUNCE_CYCLES, evt_valid high the following cycle when the FIFO was empty.
- Sampling delay: column change to `cs` is 2 cycles. SCAN_DIV ≥ 4 guarantees the sampled value belongs to the driven row.
- Row switches happen only at slot boundaries or on a return to SCAN. The driven row never changes in DEBOUNCE, HELD or RELEASE.

## Structure
- keypad_pkg:
  - state enum (SCAN, DEBOUNCE, HELD, RELEASE)
  - kp_evt_t struct {code, long}
  - key_index(row, col, cols) function
  - default key-to-value map for the 4×4 doorlock keypad (digits 0–9, A–D, *, #), used by consumers, not by this block
- Sub-module keypad_evt_fifo: synchronous FIFO of kp_evt_t, parameters FIFO_DEPTH, with push/pop/full/empty ports. The scanner FSM stays in keypad_scanner.

## Test plan
All scenarios use ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=100, FIFO_DEPTH=4.
- Clean press: key (2,1) held 50 cycles -> one event, code 9, long=0. key_down high during the hold. No further events after release.
- Bounce: column toggles every 3 cycles for 40 cycles, then stable for 20 -> exactly one event. A bounce shorter than 8 cycles alone -> no event.
- Long press: key (3,3) held 200 cycles -> events code 15 long=0, then code 15 long=1 exactly 100 cycles later. A single release glitch of 3 cycles -> no duplicate press event.
- Ghost: two columns low on row 1 -> no events, and scanning continues (row_n cycles through 0..3).
- Backpressure: evt_ready=0 with 5 distinct presses -> first 4 retained in order, overflow pulses once on the 5th. Asserting ready then drains 4 in press order.
- Reset: assert reset during HELD -> outputs return to reset values. Key still held after deassertion -> fresh press event after the re-debounce.
